// File: rtl/nec_ir_tx_if.sv
// NEC IR transmitter request/status bundle.
// Master issues requests; slave reports progress and drives the IR pins.
interface nec_ir_tx_if;
  logic       start;
  logic       rpt;
  logic [7:0] addr;
  logic [7:0] cmd;
  logic       busy;
  logic       done;
  logic       ir_env;
  logic       ir_led_out;

  modport master (
    output start, rpt, addr, cmd,
    input  busy, done, ir_env, ir_led_out
  );

  modport slave (
    input  start, rpt, addr, cmd,
    output busy, done, ir_env, ir_led_out
  );
endinterface

// File: rtl/nec_ir_tx.sv
// NEC infrared transmitter: frame/repeat envelope generator
// with a 50% duty carrier gated onto the LED during marks.
module nec_ir_tx #(
  parameter int UNIT_CYCLES  = 56250,
  parameter int CARRIER_HALF = 1316
) (
  input logic        clk,
  input logic        rst,
  nec_ir_tx_if.slave bus
);
  localparam int UW = $clog2(UNIT_CYCLES);
  localparam int CW = $clog2(2 * CARRIER_HALF);
  localparam logic [UW-1:0] UNIT_LAST = UW'(UNIT_CYCLES - 1);
  localparam logic [CW-1:0] CAR_LAST  = CW'(2 * CARRIER_HALF - 1);
  localparam logic [CW-1:0] CAR_HALF  = CW'(CARRIER_HALF);

  typedef enum logic [2:0] {
    IDLE, LEAD_MARK, LEAD_SPACE, BIT_MARK,
    BIT_SPACE, REP_SPACE, STOP_MARK
  } state_t;

  state_t        state, state_n;
  logic [UW-1:0] unit_cnt;
  logic [3:0]    units_left, units_n;
  logic [4:0]    bit_idx;
  logic [31:0]   payload;
  logic          rep;
  logic [CW-1:0] car_cnt, car_n;
  logic          unit_end, state_end, mark_n;
  logic          busy_q, done_q, env_q, led_q;

  assign unit_end  = (unit_cnt == UNIT_LAST);
  assign state_end = unit_end && (units_left == 4'd0);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    units_n = units_left;
    unique case (state)
      IDLE:
        if (bus.start) begin
          state_n = LEAD_MARK;
          units_n = 4'd15;
        end
      LEAD_MARK:
        if (state_end) begin
          state_n = rep ? REP_SPACE : LEAD_SPACE;
          units_n = rep ? 4'd3 : 4'd7;
        end
      LEAD_SPACE:
        if (state_end) begin
          state_n = BIT_MARK;
          units_n = 4'd0;
        end
      BIT_MARK:
        if (state_end) begin
          state_n = BIT_SPACE;
          units_n = payload[bit_idx] ? 4'd2 : 4'd0;
        end
      BIT_SPACE:
        if (state_end) begin
          state_n = (bit_idx == 5'd31) ? STOP_MARK : BIT_MARK;
          units_n = 4'd0;
        end
      REP_SPACE:
        if (state_end) begin
          state_n = STOP_MARK;
          units_n = 4'd0;
        end
      STOP_MARK:
        if (state_end) state_n = IDLE;
      default: state_n = IDLE;
    endcase
    mark_n = (state_n == LEAD_MARK) ||
             (state_n == BIT_MARK) ||
             (state_n == STOP_MARK);
    // Marks never follow marks, so any entry into one restarts the carrier
    if (mark_n && state_n != state)
      car_n = '0;
    else if (car_cnt == CAR_LAST)
      car_n = '0;
    else
      car_n = car_cnt + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      unit_cnt   <= '0;
      units_left <= '0;
      bit_idx    <= '0;
      payload    <= '0;
      rep        <= 1'b0;
      car_cnt    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      env_q      <= 1'b0;
      led_q      <= 1'b0;
    end else begin
      if (state_n != state) begin
        unit_cnt   <= '0;
        units_left <= units_n;
      end else if (state != IDLE) begin
        if (unit_end) begin
          unit_cnt   <= '0;
          units_left <= units_left - 4'd1;
        end else begin
          unit_cnt <= unit_cnt + UW'(1);
        end
      end
      if (state == IDLE && bus.start) begin
        payload <= {~bus.cmd, bus.cmd, ~bus.addr, bus.addr};
        rep     <= bus.rpt;
        bit_idx <= '0;
      end else if (state == BIT_SPACE && state_end) begin
        bit_idx <= bit_idx + 5'd1;
      end
      car_cnt <= car_n;
      busy_q  <= (state_n != IDLE);
      done_q  <= (state == STOP_MARK) && state_end;
      env_q   <= mark_n;
      led_q   <= mark_n && (car_n < CAR_HALF);
    end
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.ir_env     = env_q;
  assign bus.ir_led_out = led_q;
endmodule
